// File: rtl/dma_channel_regfile.sv
// dma_channel_regfile: per-channel DMA SRC/DST/LEN/CTRL registers behind the
// AXI slave controller's sys_write*/sys_read* handshakes. Drives channel
// configuration and start pulses and folds engine done/error events into
// status bits and a level interrupt.
module dma_channel_regfile #(
   parameter int REGFILE_ADDRWIDTH = 9,
   parameter int REGFILE_DATAWIDTH = 32,
   parameter int NUM_CHANNELS      = 2
) (
   input  logic                                      AXI_aclk,
   input  logic                                      AXI_aresetn,
   input  logic [REGFILE_DATAWIDTH-1:0]              sys_writeData,
   input  logic [REGFILE_ADDRWIDTH-1:0]              sys_writeAddress,
   input  logic                                      sys_writeEnable,
   output logic                                      sys_writeReady,
   input  logic [REGFILE_ADDRWIDTH-1:0]              sys_readAddress,
   input  logic                                      sys_readEnable,
   output logic [REGFILE_DATAWIDTH-1:0]              sys_readData,
   output logic                                      sys_readReady,
   output logic [NUM_CHANNELS*REGFILE_DATAWIDTH-1:0] ch_src,
   output logic [NUM_CHANNELS*REGFILE_DATAWIDTH-1:0] ch_dst,
   output logic [NUM_CHANNELS*REGFILE_DATAWIDTH-1:0] ch_len,
   output logic [NUM_CHANNELS-1:0]                   ch_start,
   input  logic [NUM_CHANNELS-1:0]                   ch_done,
   input  logic [NUM_CHANNELS-1:0]                   ch_error,
   output logic                                      irq
);
   localparam int AW  = REGFILE_ADDRWIDTH;
   localparam int DW  = REGFILE_DATAWIDTH;
   localparam int NC  = NUM_CHANNELS;
   localparam int CHW = AW - 2;

   typedef enum logic {W_IDLE, W_COMMIT} wstate_t;
   typedef enum logic {R_IDLE, R_RESP}   rstate_t;

   wstate_t              r_wstate;
   rstate_t              r_rstate;
   logic                 r_wready;
   logic                 r_rready;
   logic [DW-1:0]        r_rdata;
   logic [NC-1:0]        r_start;
   logic                 r_irq;
   logic [DW-1:0]        r_src [NC];
   logic [DW-1:0]        r_dst [NC];
   logic [DW-1:0]        r_len [NC];
   logic [NC-1:0]        r_irq_en;
   logic [NC-1:0]        r_busy;
   logic [NC-1:0]        r_done;
   logic [NC-1:0]        r_err;

   logic [CHW-1:0]       w_wch;
   logic [1:0]           w_wreg;
   logic [CHW-1:0]       w_rch;
   logic [1:0]           w_rreg;
   logic                 w_accept;
   logic [DW-1:0]        w_rval;

   assign w_wch    = sys_writeAddress[AW-1:2];
   assign w_wreg   = sys_writeAddress[1:0];
   assign w_rch    = sys_readAddress[AW-1:2];
   assign w_rreg   = sys_readAddress[1:0];
   assign w_accept = (r_wstate == W_IDLE) && sys_writeEnable;

   // Write FSM plus all register state; engine events are applied after the
   // write so that a same-edge set beats a write-1-to-clear.
   always_ff @(posedge AXI_aclk or negedge AXI_aresetn) begin
      if (!AXI_aresetn) begin
         r_wstate <= W_IDLE;
         r_wready <= 1'b1;
         r_start  <= '0;
         r_irq_en <= '0;
         r_busy   <= '0;
         r_done   <= '0;
         r_err    <= '0;
         for (int c = 0; c < NC; c++) begin
            r_src[c] <= '0;
            r_dst[c] <= '0;
            r_len[c] <= '0;
         end
      end else begin
         r_start <= '0;
         case (r_wstate)
            W_IDLE: if (sys_writeEnable) begin
               r_wstate <= W_COMMIT;
               r_wready <= 1'b0;
            end
            W_COMMIT: begin
               r_wstate <= W_IDLE;
               r_wready <= 1'b1;
            end
         endcase
         for (int c = 0; c < NC; c++) begin
            if (w_accept && (w_wch == CHW'(c))) begin
               case (w_wreg)
                  2'd0: if (!r_busy[c]) r_src[c] <= sys_writeData;
                  2'd1: if (!r_busy[c]) r_dst[c] <= sys_writeData;
                  2'd2: if (!r_busy[c]) r_len[c] <= sys_writeData;
                  2'd3: begin
                     r_irq_en[c] <= sys_writeData[1];
                     if (sys_writeData[9])  r_done[c] <= 1'b0;
                     if (sys_writeData[10]) r_err[c]  <= 1'b0;
                     // A start on an idle channel either launches or flags a zero length
                     if (sys_writeData[0] && !r_busy[c]) begin
                        if (r_len[c] != '0) begin
                           r_busy[c]  <= 1'b1;
                           r_start[c] <= 1'b1;
                        end else begin
                           r_err[c] <= 1'b1;
                        end
                     end
                  end
               endcase
            end
            if (ch_done[c]) begin
               r_busy[c] <= 1'b0;
               r_done[c] <= 1'b1;
            end
            if (ch_error[c]) begin
               r_busy[c] <= 1'b0;
               r_err[c]  <= 1'b1;
            end
         end
      end
   end

   // Read mux: addressed register value, zero when unmapped
   always_comb begin
      w_rval = '0;
      for (int c = 0; c < NC; c++) begin
         if (w_rch == CHW'(c)) begin
            case (w_rreg)
               2'd0: w_rval = r_src[c];
               2'd1: w_rval = r_dst[c];
               2'd2: w_rval = r_len[c];
               2'd3: begin
                  w_rval[1]  = r_irq_en[c];
                  w_rval[8]  = r_busy[c];
                  w_rval[9]  = r_done[c];
                  w_rval[10] = r_err[c];
               end
            endcase
         end
      end
   end

   // Read FSM: capture in R_IDLE, present a one-cycle ready in R_RESP
   always_ff @(posedge AXI_aclk or negedge AXI_aresetn) begin
      if (!AXI_aresetn) begin
         r_rstate <= R_IDLE;
         r_rready <= 1'b0;
         r_rdata  <= '0;
      end else begin
         case (r_rstate)
            R_IDLE: if (sys_readEnable) begin
               r_rstate <= R_RESP;
               r_rready <= 1'b1;
               r_rdata  <= w_rval;
            end
            R_RESP: begin
               r_rstate <= R_IDLE;
               r_rready <= 1'b0;
            end
         endcase
      end
   end

   // Interrupt lags the status bits by one cycle
   always_ff @(posedge AXI_aclk or negedge AXI_aresetn) begin
      if (!AXI_aresetn) r_irq <= 1'b0;
      else              r_irq <= |(r_irq_en & (r_done | r_err));
   end

   for (genvar g = 0; g < NC; g++) begin : g_ch
      assign ch_src[g*DW +: DW] = r_src[g];
      assign ch_dst[g*DW +: DW] = r_dst[g];
      assign ch_len[g*DW +: DW] = r_len[g];
   end

   assign sys_writeReady = r_wready;
   assign sys_readReady  = r_rready;
   assign sys_readData   = r_rdata;
   assign ch_start       = r_start;
   assign irq            = r_irq;
endmodule

// File: tb/tb_dma_channel_regfile.sv
// Bench for dma_channel_regfile: directed plan followed by random traffic,
// checked against an array-based register model.
module tb_dma_channel_regfile;
  localparam int AW = 9, DW = 32, NC = 2;

  logic clk = 1'b0, rst_n = 1'b0;
  logic [DW-1:0] wdata = '0;
  logic [AW-1:0] waddr = '0, raddr = '0;
  logic wen = 1'b0, ren = 1'b0, wrdy, rrdy, irq;
  logic [DW-1:0] rdata;
  logic [NC*DW-1:0] src, dst, len;
  logic [NC-1:0] start, done = '0, err = '0;
  int tests = 0, fails = 0;

  logic [DW-1:0] m_src [NC], m_dst [NC], m_len [NC];
  bit m_ien [NC], m_busy [NC], m_done [NC], m_err [NC];

  always #5 clk = ~clk;

  dma_channel_regfile #(.REGFILE_ADDRWIDTH(AW), .REGFILE_DATAWIDTH(DW), .NUM_CHANNELS(NC)) dut (
    .AXI_aclk(clk), .AXI_aresetn(rst_n),
    .sys_writeData(wdata), .sys_writeAddress(waddr), .sys_writeEnable(wen), .sys_writeReady(wrdy),
    .sys_readAddress(raddr), .sys_readEnable(ren), .sys_readData(rdata), .sys_readReady(rrdy),
    .ch_src(src), .ch_dst(dst), .ch_len(len), .ch_start(start),
    .ch_done(done), .ch_error(err), .irq(irq));

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    for (int c = 0; c < NC; c++) begin
      m_src[c] = 0; m_dst[c] = 0; m_len[c] = 0;
      m_ien[c] = 0; m_busy[c] = 0; m_done[c] = 0; m_err[c] = 0;
    end
  endfunction

  function automatic logic [DW-1:0] m_read(input int a);
    logic [DW-1:0] v;
    int ch, rg;
    v = '0; ch = a / 4; rg = a % 4;
    if (ch >= NC) return v;
    if (rg == 0) v = m_src[ch];
    else if (rg == 1) v = m_dst[ch];
    else if (rg == 2) v = m_len[ch];
    else begin
      v[1] = m_ien[ch]; v[8] = m_busy[ch]; v[9] = m_done[ch]; v[10] = m_err[ch];
    end
    return v;
  endfunction

  function automatic bit m_irq();
    bit r;
    r = 0;
    for (int c = 0; c < NC; c++) r |= m_ien[c] & (m_done[c] | m_err[c]);
    return r;
  endfunction

  // Applies one accepted write; returns the start pulses it should produce.
  function automatic logic [NC-1:0] model_write(input int a, input logic [DW-1:0] d);
    logic [NC-1:0] s;
    int ch, rg;
    s = '0; ch = a / 4; rg = a % 4;
    if (ch >= NC) return s;
    if (rg == 0) begin if (!m_busy[ch]) m_src[ch] = d; end
    else if (rg == 1) begin if (!m_busy[ch]) m_dst[ch] = d; end
    else if (rg == 2) begin if (!m_busy[ch]) m_len[ch] = d; end
    else begin
      m_ien[ch] = d[1];
      if (d[9]) m_done[ch] = 0;
      if (d[10]) m_err[ch] = 0;
      if (d[0] && !m_busy[ch]) begin
        if (m_len[ch] != 0) begin m_busy[ch] = 1; s[ch] = 1'b1; end
        else m_err[ch] = 1;
      end
    end
    return s;
  endfunction

  function automatic void model_events(input logic [NC-1:0] ed, input logic [NC-1:0] ee);
    for (int c = 0; c < NC; c++) begin
      if (ed[c]) begin m_busy[c] = 0; m_done[c] = 1; end
      if (ee[c]) begin m_busy[c] = 0; m_err[c] = 1; end
    end
  endfunction

  task automatic check_cfg();
    for (int c = 0; c < NC; c++) begin
      check($sformatf("ch_src%0d", c), src[c*DW +: DW], m_src[c]);
      check($sformatf("ch_dst%0d", c), dst[c*DW +: DW], m_dst[c]);
      check($sformatf("ch_len%0d", c), len[c*DW +: DW], m_len[c]);
    end
  endtask

  task automatic do_write(input int a, input logic [DW-1:0] d,
                          input logic [NC-1:0] ed = '0, input logic [NC-1:0] ee = '0);
    logic [NC-1:0] s;
    bit ib;
    @(negedge clk);
    check("wready_idle", wrdy, 1);
    waddr = AW'(a); wdata = d; wen = 1'b1; done = ed; err = ee;
    ib = m_irq();
    @(posedge clk);
    s = model_write(a, d);
    model_events(ed, ee);
    #1;
    check("wready_commit", wrdy, 0);
    check("ch_start", start, s);
    check("irq_lag", irq, ib);
    check_cfg();
    @(negedge clk);
    wen = 1'b0; done = '0; err = '0;
    @(posedge clk); #1;
    check("wready_back", wrdy, 1);
    check("ch_start_off", start, 0);
    check("irq", irq, m_irq());
  endtask

  task automatic do_read(input int a);
    logic [DW-1:0] e;
    @(negedge clk);
    raddr = AW'(a); ren = 1'b1;
    e = m_read(a);
    @(posedge clk); #1;
    check("rready", rrdy, 1);
    check($sformatf("rdata@%0h", a), rdata, e);
    @(negedge clk);
    ren = 1'b0;
    @(posedge clk); #1;
    check("rready_off", rrdy, 0);
    check("rdata_hold", rdata, e);
  endtask

  task automatic pulse(input logic [NC-1:0] ed, input logic [NC-1:0] ee);
    bit ib;
    @(negedge clk);
    done = ed; err = ee;
    ib = m_irq();
    @(posedge clk);
    model_events(ed, ee);
    #1 check("irq_pre", irq, ib);
    @(negedge clk);
    done = '0; err = '0;
    @(posedge clk); #1;
    check("irq_post", irq, m_irq());
  endtask

  initial begin
    int op, a;
    logic [DW-1:0] d;
    logic [NC-1:0] ed, ee;

    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    #1;
    check("rst_wready", wrdy, 1);
    check("rst_rready", rrdy, 0);
    check("rst_rdata", rdata, 0);
    check("rst_irq", irq, 0);
    check("rst_start", start, 0);
    check_cfg();
    do_read(3);

    // Program and start channel 0
    do_write(0, 32'h1000);
    do_write(1, 32'h2000);
    do_write(2, 32'h40);
    do_write(3, 32'h003);
    do_read(3);
    check("ctrl0_busy", m_read(3), 32'h102);

    // Busy protection
    do_write(2, 32'h80);
    do_write(3, 32'h001);
    pulse(2'b01, 2'b00);
    do_read(3);

    // Done set beats a same-edge write-1-to-clear, then a later clear drops irq
    do_write(3, 32'h202, 2'b01, 2'b00);
    do_read(3);
    do_write(3, 32'h202);
    do_read(3);

    // Zero-length start on channel 1
    do_write(7, 32'h001);
    do_read(7);

    // Unmapped accesses
    do_write(9'h1FC, 32'hFFFF_FFFF);
    do_write(8, 32'h1234_5678);
    do_read(9'h1FC);
    do_read(8);

    // Same-edge read and write of one register returns the old value
    @(negedge clk);
    waddr = 0; wdata = 32'hCAFE_0000; wen = 1'b1;
    raddr = 0; ren = 1'b1;
    d = m_read(0);
    @(posedge clk);
    void'(model_write(0, 32'hCAFE_0000));
    #1 check("rw_same_edge", rdata, d);
    @(negedge clk); wen = 1'b0; ren = 1'b0;
    @(posedge clk);
    do_read(0);

    // Random traffic
    for (int i = 0; i < 80; i++) begin
      op = $urandom_range(0, 3);
      a = $urandom_range(0, 7);
      if ($urandom_range(0, 15) == 0) a = 9'h1FC;
      d = $urandom;
      if (a % 4 == 3) d = d & 32'h0000_0703;
      if (a % 4 == 2 && $urandom_range(0, 3) == 0) d = 0;
      ed = NC'($urandom_range(0, 3)) & NC'($urandom_range(0, 3));
      ee = NC'($urandom_range(0, 3)) & NC'($urandom_range(0, 3)) & NC'($urandom_range(0, 3));
      case (op)
        0: do_write(a, d);
        1: do_read(a);
        2: pulse(ed, ee);
        default: do_write(a, d, ed, ee);
      endcase
    end

    // Reset in the middle of a start commit
    pulse(2'b01, 2'b00);
    do_write(2, 32'h10);
    @(negedge clk);
    waddr = 3; wdata = 32'h003; wen = 1'b1;
    @(posedge clk); #1;
    check("pre_reset_start", start, 2'b01);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_wready", wrdy, 1);
    check("midrst_start", start, 0);
    check("midrst_irq", irq, 0);
    check("midrst_rready", rrdy, 0);
    wen = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    model_reset();
    #1 check_cfg();
    for (int k = 0; k < 8; k++) do_read(k);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
